// File: rtl/regfile_write_if.sv
// Bus bundle for the register-file write side: write/clear requests in,
// acknowledge, busy flag and the 32 parallel register outputs back.
interface regfile_write_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       Awr;
    logic [WIDTH-1:0] Win;
    logic             Wen;
    logic             Clr;
    logic             Wack;
    logic             Busy;
    logic [WIDTH-1:0] Dout [32];

    modport master (output Awr, Win, Wen, Clr, input Wack, Busy, Dout);
    modport slave  (input Awr, Win, Wen, Clr, output Wack, Busy, Dout);
endinterface

// File: rtl/regfile_write.sv
// Write side of the 32-entry register file: addressed writes with a one-cycle
// acknowledge, plus a sequenced bulk clear that walks every register to zero.
module regfile_write #(
    parameter int WIDTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input logic           Clk,
    input logic           Rst_n,
    regfile_write_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, next_state;
    logic [4:0]       cnt, next_cnt;
    logic             wack, next_wack;
    logic             we;
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] regs [32];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            wack  <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            wack  <= next_wack;
            if (we) regs[wa] <= wd;
        end
    end

    // One shared write port: the clear sequence and host writes never coincide.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_wack  = 1'b0;
        we         = 1'b0;
        wa         = bus.Awr;
        wd         = bus.Win;
        unique case (state)
            IDLE: begin
                if (bus.Clr) begin
                    next_state = CLEAR;
                    next_cnt   = ZERO_REG ? 5'd1 : 5'd0;
                end else if (bus.Wen) begin
                    next_wack = 1'b1;
                    we        = !(ZERO_REG && bus.Awr == 5'd0);
                end
            end
            CLEAR: begin
                we = 1'b1;
                wa = cnt;
                wd = '0;
                if (cnt == 5'd31) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 5'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.Wack = wack;
    assign bus.Busy = (state == CLEAR);
    assign bus.Dout = regs;
endmodule

// File: tb/tb_regfile_write.sv
// Randomized self-checking bench for regfile_write against a behavioural model
// of the register array and the clear sequence.
module tb_regfile_write;
    localparam int WIDTH    = 32;
    localparam bit ZERO_REG = 1'b1;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    regfile_write_if #(.WIDTH(WIDTH)) bus ();

    regfile_write #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    // Reference model: register contents, expected ack, and clear progress
    logic [WIDTH-1:0] mem [32];
    logic             m_wack;
    bit               m_busy;
    int               m_idx;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("wack", {31'd0, bus.Wack}, {31'd0, m_wack});
        chk("busy", {31'd0, bus.Busy}, {31'd0, m_busy});
        for (int i = 0; i < 32; i++) chk($sformatf("dout%0d", i), bus.Dout[i], mem[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        m_wack = 1'b0;
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    // Apply inputs, advance one edge, update the model, then compare.
    task automatic cycle(input bit wen, input bit clr, input logic [4:0] awr, input logic [WIDTH-1:0] win);
        bus.Wen = wen;
        bus.Clr = clr;
        bus.Awr = awr;
        bus.Win = win;
        @(posedge Clk);
        m_wack = 1'b0;
        if (m_busy) begin
            mem[m_idx] = '0;
            if (m_idx == 31) m_busy = 1'b0;
            else m_idx = m_idx + 1;
        end else if (clr) begin
            m_busy = 1'b1;
            m_idx  = ZERO_REG ? 1 : 0;
        end else if (wen) begin
            m_wack = 1'b1;
            if (!(ZERO_REG && awr == 5'd0)) mem[awr] = win;
        end
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        bus.Wen = 1'b0;
        bus.Clr = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        int busy_len;
        bus.Wen = 1'b0;
        bus.Clr = 1'b0;
        bus.Awr = '0;
        bus.Win = '0;
        model_reset();
        #1;
        check_all();
        #2;
        Rst_n = 1'b1;

        // Random prior contents, then reset without a clock edge
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 5'(i), $urandom);
        mid_reset();

        // Single write and discarded write to register 0
        cycle(1'b1, 1'b0, 5'd13, 32'hDEADBEEF);
        cycle(1'b0, 1'b0, 5'd0, '0);
        chk("dout13_hold", bus.Dout[13], 32'hDEADBEEF);
        cycle(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
        chk("dout0_zero", bus.Dout[0], '0);
        cycle(1'b0, 1'b0, 5'd0, '0);

        // Fill 1..31, clear with writes attempted during Busy
        for (int i = 1; i < 32; i++) cycle(1'b1, 1'b0, 5'(i), WIDTH'(i));
        cycle(1'b0, 1'b1, 5'd0, '0);
        busy_len = bus.Busy ? 1 : 0;
        for (int k = 0; k < 40 && bus.Busy; k++) begin
            cycle(1'b1, 1'b0, 5'd5, 32'd7);
            if (bus.Busy) busy_len++;
        end
        chk("busy_len", WIDTH'(busy_len), 32'd31);
        chk("dout5_cleared", bus.Dout[5], '0);
        cycle(1'b0, 1'b0, 5'd0, '0);

        // Clear and write on the same edge: clear wins
        cycle(1'b1, 1'b0, 5'd22, 32'h1234);
        cycle(1'b1, 1'b1, 5'd22, 32'd22);
        for (int k = 0; k < 40 && bus.Busy; k++) cycle(1'b0, 1'b0, 5'd0, '0);
        chk("dout22_cleared", bus.Dout[22], '0);

        // Reset during clear cycle 10, then a normal write
        for (int i = 1; i < 32; i++) cycle(1'b1, 1'b0, 5'(i), $urandom);
        cycle(1'b0, 1'b1, 5'd0, '0);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, 5'd0, '0);
        mid_reset();
        cycle(1'b1, 1'b0, 5'd5, 32'd5);
        chk("dout5_after_rst", bus.Dout[5], 32'd5);

        // Random traffic
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                  5'($urandom_range(0, 31)), $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
